uart_parity_engine: RTL and testbench
=====================================

# uart_parity_engine

Parametrised parity unit shared by the UART TX and RX paths. It generates the TX parity bit from a captured word and checks the received parity bit against bits accumulated serially during RX. Data width, active character length (`data_len`) and parity mode (even, odd, mark, space) are all configurable. It sits beside the TX and RX frame FSMs, which drive its capture and bit strobes.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: maximum character width in bits (≥ 5).
- `LEN_W`, default `$clog2(DATA_WIDTH+1)`: width of `data_len`; localparam, not overridable.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `par_en` in 1: 1 = parity bit present in frame.
- `par_mode` in 2: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0).
- `data_len` in LEN_W: active bits per character; 0 or > DATA_WIDTH is treated as DATA_WIDTH.
- `tx_data` in DATA_WIDTH: TX word, LSB first on line.
- `tx_capture` in 1: strobe that latches `tx_data`, `par_en`, `par_mode` and `data_len`.
- `tx_parity` out 1: TX parity bit.
- `tx_par_valid` out 1: `tx_parity` corresponds to the last capture.
- `rx_start` in 1: strobe for a start bit accepted; begins a new RX character.
- `rx_bit_valid` in 1: strobe for one sampled RX bit.
- `rx_bit` in 1: sampled RX bit value.
- `rx_busy` out 1: RX FSM not in IDLE.
- `rx_par_done` out 1: one-cycle pulse when the character (and parity bit, if enabled) is complete.
- `rx_par_err` out 1: valid only with `rx_par_done`; 1 = parity mismatch.

## Operation
- Reset: `tx_parity`=0, `tx_par_valid`=0, `rx_busy`=0, `rx_par_done`=0, `rx_par_err`=0. The RX FSM enters IDLE and all internal registers are cleared.

Parity function `f(mode, x)`, where `x` is the XOR of the active bits:
- even → x
- odd → ~x
- mark → 1
- space → 0
- `par_en`=0 forces the result to 0.

TX path:
- `tx_capture` stores `tx_data` masked to its `data_len` LSBs, plus the config, into shadow registers.
- Upper bits beyond `data_len` never affect parity.
- `tx_parity` = `f(latched mode, ^masked word)` and is registered.
- Config changes after capture do not affect `tx_parity`.

RX FSM has three states: IDLE, DATA and PARITY.
- `rx_start` in any state:
  - latches `par_en`, `par_mode` and `data_len`;
  - clears the accumulator and bit counter;
  - moves to DATA.
  - `rx_start` has priority over a simultaneous `rx_bit_valid`; that bit is dropped.
- DATA, on each `rx_bit_valid`:
  - `acc ^= rx_bit`, `cnt++`.
  - When `cnt` reaches the latched length, go to PARITY if `par_en`.
  - Otherwise go to IDLE with `rx_par_done`=1 and `rx_par_err`=0.
- PARITY, on `rx_bit_valid`:
  - `rx_par_err = rx_bit != f(mode, acc)` and `rx_par_done`=1.
  - Go to IDLE.
- IDLE: `rx_bit_valid` is ignored. Stop bits are the frame FSM's concern.
- `rx_busy` = state ≠ IDLE.

## Timing
- TX: `tx_capture` is sampled at edge N. `tx_par_valid` goes 0 at edge N and 1 at edge N+1, when `tx_parity` is updated. Latency is 1 cycle after capture.
- Back-to-back captures: each capture restarts the sequence. The last one wins; there is no queueing.
- RX: `rx_par_done` and `rx_par_err` are registered. They assert on the edge that consumes the final bit and last exactly one cycle.
- `rx_par_err` is 0 whenever `rx_par_done` is 0.
- Reset asserted mid-character clears outputs immediately (asynchronous). After release, the FSM stays in IDLE until the next `rx_start`.
- Counter width is LEN_W. The counter never wraps, because the transition fires at equality.

## Structure
- Shared package `uart_parity_pkg`:
  - `par_mode` encodings `PAR_EVEN`, `PAR_ODD`, `PAR_MARK`, `PAR_SPACE`;
  - RX state enum (IDLE, DATA, PARITY);
  - function `calc_parity(en, mode, x)`;
  - function `len_mask(len)`, which maps length to a DATA_WIDTH mask and clamps 0/overflow.
- Single module; no sub-module. The TX and RX paths share only the package functions.

## Test plan
- **TX even/odd:** DATA_WIDTH=8, len 8, capture 0xA7 (five ones). Even → `tx_parity`=1; odd → 0. `tx_par_valid` rises 1 cycle after the capture edge.
- **TX length mask:** len 5, capture 0xFF (masked 0x1F, five ones), even → 1. Len 0 is treated as 8 (eight ones) → 0. Changing `par_mode` after capture leaves `tx_parity` unchanged.
- **Mark/space/disabled:** any data gives mark → 1 and space → 0. `par_en`=0 gives 0.
- **RX check:** len 8, even, bits of 0x35 LSB-first (four ones), then parity bit 0 → `rx_par_done`=1, `rx_par_err`=0. Repeat with parity bit 1 → `rx_par_err`=1. Both outputs last exactly 1 cycle, and `rx_busy` falls on the same edge.
- **RX restart and no-parity:** `rx_start` after 3 bits, with a simultaneous `rx_bit_valid`, restarts the count; only the following 8 bits plus parity are judged. With `par_en`=0, `rx_par_done` fires on the 8th bit and no parity bit is consumed.
- **Reset mid-frame:** drop `rst_n` during DATA → all outputs 0 and state IDLE. Subsequent `rx_bit_valid` produces no `rx_par_done` until `rx_start`.

Source files
------------

// File: rtl/uart_parity_pkg.sv
// Shared types and helpers for the UART parity engine.
// Parity modes, RX state encoding, parity and length-mask functions.
package uart_parity_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'b00,
    RX_DATA   = 2'b01,
    RX_PARITY = 2'b10
  } rx_state_t;

  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned width
  );
    if (len == 0 || len > width) begin
      return width;
    end
    return len;
  endfunction

  function automatic logic [MAX_W-1:0] len_mask(
    input int unsigned len,
    input int unsigned width
  );
    int unsigned l;
    logic [MAX_W-1:0] m;
    l = clamp_len(len, width);
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < l) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic calc_parity(
    input logic      en,
    input par_mode_t mode,
    input logic      x
  );
    logic p;
    unique case (mode)
      PAR_EVEN:  p = x;
      PAR_ODD:   p = ~x;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return en & p;
  endfunction

endpackage

// File: rtl/uart_parity_engine.sv
// UART parity unit: registered TX parity generation from a captured
// word and serial RX parity accumulation/check with a small FSM.
module uart_parity_engine
  import uart_parity_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int LEN_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  input  logic [LEN_W-1:0]      data_len,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_capture,
  output logic                  tx_parity,
  output logic                  tx_par_valid,
  input  logic                  rx_start,
  input  logic                  rx_bit_valid,
  input  logic                  rx_bit,
  output logic                  rx_busy,
  output logic                  rx_par_done,
  output logic                  rx_par_err
);

  par_mode_t             mode_in;
  logic [DATA_WIDTH-1:0] tx_mask;
  logic [LEN_W-1:0]      eff_len;

  assign mode_in = par_mode_t'(par_mode);
  assign tx_mask = DATA_WIDTH'(len_mask(32'(data_len), DATA_WIDTH));
  assign eff_len = LEN_W'(clamp_len(32'(data_len), DATA_WIDTH));

  logic [DATA_WIDTH-1:0] tx_word_q;
  logic                  tx_en_q;
  par_mode_t             tx_mode_q;
  logic                  tx_pend_q;
  logic                  tx_par_q;
  logic                  tx_vld_q;

  // Parity is computed one cycle after capture from the shadow copy,
  // so later config changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word_q <= '0;
      tx_en_q   <= 1'b0;
      tx_mode_q <= PAR_EVEN;
      tx_pend_q <= 1'b0;
      tx_par_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
    end else if (tx_capture) begin
      tx_word_q <= tx_data & tx_mask;
      tx_en_q   <= par_en;
      tx_mode_q <= mode_in;
      tx_pend_q <= 1'b1;
      tx_vld_q  <= 1'b0;
    end else if (tx_pend_q) begin
      tx_par_q  <= calc_parity(tx_en_q, tx_mode_q, ^tx_word_q);
      tx_pend_q <= 1'b0;
      tx_vld_q  <= 1'b1;
    end
  end

  assign tx_parity    = tx_par_q;
  assign tx_par_valid = tx_vld_q;

  rx_state_t        state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             en_q, en_d;
  par_mode_t        mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      en_q    <= 1'b0;
      mode_q  <= PAR_EVEN;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    en_d    = en_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // A start strobe wins over any bit arriving in the same cycle.
    if (rx_start) begin
      len_d   = eff_len;
      en_d    = par_en;
      mode_d  = mode_in;
      acc_d   = 1'b0;
      cnt_d   = '0;
      state_d = RX_DATA;
    end else if (rx_bit_valid) begin
      unique case (state_q)
        RX_DATA: begin
          acc_d = acc_q ^ rx_bit;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            if (en_q) begin
              state_d = RX_PARITY;
            end else begin
              state_d = RX_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        RX_PARITY: begin
          err_d   = rx_bit != calc_parity(en_q, mode_q, acc_q);
          done_d  = 1'b1;
          state_d = RX_IDLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign rx_busy     = state_q != RX_IDLE;
  assign rx_par_done = done_q;
  assign rx_par_err  = err_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine (DATA_WIDTH = 8).
// Table-driven TX vectors, directed RX sequences, random vs. model.
module tb_uart_parity_engine;

  logic       clk;
  logic       rst_n;
  logic       par_en;
  logic [1:0] par_mode;
  logic [3:0] data_len;
  logic [7:0] tx_data;
  logic       tx_capture;
  logic       tx_parity;
  logic       tx_par_valid;
  logic       rx_start;
  logic       rx_bit_valid;
  logic       rx_bit;
  logic       rx_busy;
  logic       rx_par_done;
  logic       rx_par_err;

  int checks = 0;
  int errors = 0;

  uart_parity_engine #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .par_en       (par_en),
    .par_mode     (par_mode),
    .data_len     (data_len),
    .tx_data      (tx_data),
    .tx_capture   (tx_capture),
    .tx_parity    (tx_parity),
    .tx_par_valid (tx_par_valid),
    .rx_start     (rx_start),
    .rx_bit_valid (rx_bit_valid),
    .rx_bit       (rx_bit),
    .rx_busy      (rx_busy),
    .rx_par_done  (rx_par_done),
    .rx_par_err   (rx_par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [3:0] len;
    logic [7:0] data;
    logic       exp;
  } tx_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(logic [3:0] len);
    if (len == 0 || len > 8) return 8;
    return int'(len);
  endfunction

  // Reference: count ones among active bits, then apply the mode rule.
  function automatic logic model_par(logic en, logic [1:0] mode,
                                     logic [3:0] len, logic [7:0] d);
    int ones = 0;
    int l = eff_len(len);
    for (int i = 0; i < l; i++) ones += int'(d[i]);
    if (!en) return 1'b0;
    case (mode)
      2'd0: return (ones % 2) == 1;
      2'd1: return (ones % 2) == 0;
      2'd2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tx_run(string name, logic en, logic [1:0] mode,
                        logic [3:0] len, logic [7:0] d, logic exp);
    par_en = en; par_mode = mode; data_len = len; tx_data = d;
    tx_capture = 1'b1;
    step();
    tx_capture = 1'b0;
    check({name, "_vld0"}, 32'(tx_par_valid), 32'd0);
    step();
    check({name, "_vld1"}, 32'(tx_par_valid), 32'd1);
    check({name, "_par"}, 32'(tx_parity), 32'(exp));
  endtask

  // Drives one RX character; optional collision of a bit with the start.
  task automatic rx_frame(string name, logic en, logic [1:0] mode,
                          logic [3:0] len, logic [7:0] d, logic pbit,
                          logic collide);
    int l = eff_len(len);
    logic exp_err = pbit != model_par(en, mode, len, d);
    int early = 0;
    par_en = en; par_mode = mode; data_len = len;
    rx_start = 1'b1;
    rx_bit_valid = collide; rx_bit = 1'b1;
    step();
    rx_start = 1'b0;
    check({name, "_busy"}, 32'(rx_busy), 32'd1);
    par_en = $urandom_range(0, 1);
    par_mode = 2'($urandom_range(0, 3));
    data_len = 4'($urandom_range(0, 15));
    for (int i = 0; i < l; i++) begin
      rx_bit_valid = 1'b1; rx_bit = d[i];
      step();
      if (i < l - 1 && rx_par_done) early++;
    end
    check({name, "_early"}, 32'(early), 32'd0);
    if (!en) begin
      check({name, "_done"}, 32'(rx_par_done), 32'd1);
      check({name, "_err"}, 32'(rx_par_err), 32'd0);
      check({name, "_idle"}, 32'(rx_busy), 32'd0);
    end else begin
      check({name, "_wait"}, 32'({rx_par_done, rx_busy}), 32'b01);
      rx_bit = pbit;
      step();
      check({name, "_done"}, 32'(rx_par_done), 32'd1);
      check({name, "_err"}, 32'(rx_par_err), 32'(exp_err));
      check({name, "_idle"}, 32'(rx_busy), 32'd0);
    end
    rx_bit_valid = 1'b0;
    step();
    check({name, "_pulse"}, 32'({rx_par_done, rx_par_err}), 32'd0);
  endtask

  tx_vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 2'd0, 4'd8, 8'hA7, 1'b1};
    vecs[1] = '{1'b1, 2'd1, 4'd8, 8'hA7, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 4'd5, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 2'd0, 4'd0, 8'hFF, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 4'd8, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 2'd3, 4'd8, 8'hFF, 1'b0};
    vecs[6] = '{1'b0, 2'd1, 4'd8, 8'hA7, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 4'd9, 8'h01, 1'b0};
    vecs[8] = '{1'b1, 2'd1, 4'd3, 8'hF8, 1'b1};

    rst_n = 1'b0;
    par_en = 1'b0; par_mode = 2'd0; data_len = 4'd0;
    tx_data = 8'h00; tx_capture = 1'b0;
    rx_start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
    repeat (2) step();
    check("rst_outs", 32'({tx_parity, tx_par_valid, rx_busy,
                           rx_par_done, rx_par_err}), 32'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      tx_run($sformatf("tx_vec%0d", i), vecs[i].en, vecs[i].mode,
             vecs[i].len, vecs[i].data, vecs[i].exp);
    end

    tx_run("tx_hold", 1'b1, 2'd0, 4'd8, 8'hA7, 1'b1);
    par_mode = 2'd1; par_en = 1'b0; data_len = 4'd1; tx_data = 8'h00;
    repeat (2) step();
    check("tx_hold_after", 32'({tx_parity, tx_par_valid}), 32'b11);

    tx_data = 8'h01; par_en = 1'b1; par_mode = 2'd0; data_len = 4'd8;
    tx_capture = 1'b1;
    step();
    tx_data = 8'h03;
    step();
    tx_capture = 1'b0;
    check("tx_b2b_vld", 32'(tx_par_valid), 32'd0);
    step();
    check("tx_b2b_par", 32'({tx_parity, tx_par_valid}), 32'b01);

    for (int i = 0; i < 40; i++) begin
      logic       en = $urandom_range(0, 1);
      logic [1:0] md = 2'($urandom_range(0, 3));
      logic [3:0] ln = 4'($urandom_range(0, 15));
      logic [7:0] dd = 8'($urandom);
      tx_run($sformatf("tx_rnd%0d", i), en, md, ln, dd,
             model_par(en, md, ln, dd));
    end

    rx_frame("rx_ok", 1'b1, 2'd0, 4'd8, 8'h35, 1'b0, 1'b0);
    rx_frame("rx_bad", 1'b1, 2'd0, 4'd8, 8'h35, 1'b1, 1'b0);
    rx_frame("rx_nopar", 1'b0, 2'd0, 4'd8, 8'h35, 1'b0, 1'b0);
    rx_frame("rx_mark", 1'b1, 2'd2, 4'd5, 8'h00, 1'b0, 1'b0);

    par_en = 1'b1; par_mode = 2'd0; data_len = 4'd8;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      step();
    end
    rx_frame("rx_restart", 1'b1, 2'd0, 4'd8, 8'h35, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b0;
      step();
    end
    rx_bit_valid = 1'b0;
    check("rx_idle_ign", 32'({rx_busy, rx_par_done}), 32'd0);

    tx_run("tx_prerst", 1'b1, 2'd2, 4'd8, 8'h00, 1'b1);
    par_en = 1'b1; par_mode = 2'd0; data_len = 4'd8;
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_bit_valid = 1'b1; rx_bit = 1'b1;
      step();
    end
    check("rst_mid_busy", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", 32'({tx_parity, tx_par_valid, rx_busy,
                               rx_par_done, rx_par_err}), 32'd0);
    step();
    rst_n = 1'b1;
    begin
      int pulses = 0;
      int busy = 0;
      for (int i = 0; i < 10; i++) begin
        rx_bit_valid = 1'b1; rx_bit = i[0];
        step();
        pulses += int'(rx_par_done);
        busy += int'(rx_busy);
      end
      rx_bit_valid = 1'b0;
      check("rst_no_done", 32'(pulses), 32'd0);
      check("rst_stay_idle", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic       en = $urandom_range(0, 1);
      logic [1:0] md = 2'($urandom_range(0, 3));
      logic [3:0] ln = 4'($urandom_range(0, 15));
      logic [7:0] dd = 8'($urandom);
      logic       pb = $urandom_range(0, 1);
      rx_frame($sformatf("rx_rnd%0d", i), en, md, ln, dd, pb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
